// File: rtl/rom_stream_loader_pkg.sv
// Shared types and defaults for the ROM stream loader.
// Tagged words carry matrix type and position alongside the ROM data.
package rom_stream_loader_pkg;

    localparam int DATA_W       = 16;
    localparam int IFMAP_SIZE_D = 7;
    localparam int FILT_SIZE_D  = 3;
    localparam int IFMAP_BASE_D = 0;
    localparam int FILT_BASE_D  = 49;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILT,
        ST_IFMAP,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic       is_filt;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              is_filt;
        logic [2:0]        row;
        logic [2:0]        col;
        logic              last;
    } tagged_word_t;

endpackage

// File: rtl/rom_stream_loader_stream_fifo2.sv
// Two-entry FIFO of tagged words; head entry is presented on dout.
// Storage is reset to zero so the head reads as zero when empty after reset.
module stream_fifo2
    import rom_stream_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  tagged_word_t din,
    input  logic         pop,
    output tagged_word_t dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    tagged_word_t mem_q [2];
    tagged_word_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push_ok) - 2'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rom_stream_loader.sv
// Walks the filter then ifmap ROM regions and streams tagged words out.
// Reads are throttled so FIFO entries plus the in-flight word never exceed two.
module rom_stream_loader
    import rom_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = 6,
    parameter int IFMAP_SIZE = IFMAP_SIZE_D,
    parameter int FILT_SIZE  = FILT_SIZE_D,
    parameter int IFMAP_BASE = IFMAP_BASE_D,
    parameter int FILT_BASE  = FILT_BASE_D
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rom_read,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_is_filt,
    output logic [2:0]            out_row,
    output logic [2:0]            out_col,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int IFMAP_WORDS = IFMAP_SIZE * IFMAP_SIZE;
    localparam int FILT_WORDS  = FILT_SIZE * FILT_SIZE;
    localparam int CNT_W       = $clog2(IFMAP_WORDS);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            row_q, row_d;
    logic [2:0]            col_q, col_d;
    logic                  inflight_q, inflight_d;
    tag_t                  pend_q, pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    tagged_word_t          push_word;
    tagged_word_t          head;
    logic [1:0]            fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic [2:0]            occ;
    logic                  issuing;
    logic                  is_filt;
    logic                  region_last;
    logic [2:0]            side_max;
    logic                  rd_en;

    assign pop     = !fifo_empty && out_ready;
    assign occ     = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issuing = (state_q == ST_FILT) || (state_q == ST_IFMAP);
    assign is_filt = (state_q == ST_FILT);
    assign rd_en   = issuing && (occ < 3'd2) && !(fifo_full && !pop);

    assign side_max    = is_filt ? 3'(FILT_SIZE - 1) : 3'(IFMAP_SIZE - 1);
    assign region_last = is_filt ? (cnt_q == CNT_W'(FILT_WORDS - 1))
                                 : (cnt_q == CNT_W'(IFMAP_WORDS - 1));

    // ROM data is only looked at in the cycle after a read.
    always_comb begin
        push_word         = '0;
        push_word.data    = inflight_q ? rom_dout : '0;
        push_word.is_filt = pend_q.is_filt;
        push_word.row     = pend_q.row;
        push_word.col     = pend_q.col;
        push_word.last    = pend_q.last;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = rd_en;
        pend_d     = pend_q;
        if (rd_en) begin
            pend_d.is_filt = is_filt;
            pend_d.row     = row_q;
            pend_d.col     = col_q;
            pend_d.last    = region_last;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILT;
                    busy_d  = 1'b1;
                    addr_d  = ADDR_WIDTH'(FILT_BASE);
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_FILT, ST_IFMAP: begin
                if (rd_en) begin
                    if (region_last) begin
                        cnt_d = '0;
                        row_d = '0;
                        col_d = '0;
                        if (is_filt) begin
                            state_d = ST_IFMAP;
                            addr_d  = ADDR_WIDTH'(IFMAP_BASE);
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                        if (col_q == side_max) begin
                            col_d = '0;
                            row_d = row_q + 3'd1;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && fifo_empty) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            pend_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    stream_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   (push_word),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rom_read    = rd_en;
    assign rom_addr    = addr_q;
    assign out_valid   = !fifo_empty;
    assign out_data    = head.data;
    assign out_is_filt = head.is_filt;
    assign out_row     = head.row;
    assign out_col     = head.col;
    assign out_last    = head.last;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rom_stream_loader.sv
// Randomized bench for rom_stream_loader against a word-sequence model.
// A registered ROM model returns X whenever it was not read.
module tb_rom_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rom_read;
    logic [5:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_is_filt;
    logic [2:0]  out_row;
    logic [2:0]  out_col;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom_mem [64];
    logic [23:0] exp_word [58];
    logic [5:0]  exp_addr [58];

    int widx      = 0;
    int issue_idx = 0;
    int rd_cnt    = 0;
    int pop_cnt   = 0;
    int done_cnt  = 0;
    int cyc_rel   = 1000;
    bit prev_stall = 1'b0;
    logic [23:0] prev_word = '0;

    always #5 clk = ~clk;

    rom_stream_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rom_read    (rom_read),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_is_filt (out_is_filt),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always @(posedge clk) begin
        if (rom_read) rom_dout <= rom_mem[rom_addr];
        else          rom_dout <= 'x;
    end

    task automatic check(input string nm, input bit ok,
                         input longint act, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, expv, $time);
        end
    endtask

    // Expected stream: 3x3 filter row-major, then 7x7 ifmap row-major.
    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'(i + 16'h0100);
        for (int k = 0; k < 58; k++) begin
            int a, idx, side;
            bit f;
            f    = (k < 9);
            idx  = f ? k : k - 9;
            side = f ? 3 : 7;
            a    = f ? 49 + idx : idx;
            exp_addr[k] = 6'(a);
            exp_word[k] = {16'(a + 16'h0100), f, 3'(idx / side),
                           3'(idx % side), (idx == side * side - 1)};
        end
    end

    always @(negedge clk) begin
        logic [23:0] cur;
        bit pop;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur = {out_data, out_is_filt, out_row, out_col, out_last};
            pop = out_valid && out_ready;
            if (start && !busy) begin
                widx = 0; issue_idx = 0; rd_cnt = 0;
                pop_cnt = 0; done_cnt = 0; cyc_rel = 0;
            end else begin
                cyc_rel++;
            end
            if (cyc_rel == 1)
                check("first_issue", rom_read && rom_addr == 6'd49 && busy,
                      {rom_read, busy, rom_addr}, {2'b11, 6'd49});
            if (cyc_rel == 2)
                check("valid_not_early", !out_valid, out_valid, 0);
            if (cyc_rel == 3)
                check("first_word_lat", out_valid && out_data == 16'h0131,
                      {out_valid, out_data}, {1'b1, 16'h0131});
            if (out_valid) begin
                check("data_known", !$isunknown(cur), cur, 0);
                if (widx < 58)
                    check($sformatf("word%0d", widx), cur == exp_word[widx],
                          cur, exp_word[widx]);
                else
                    check("extra_word", 1'b0, cur, 0);
                if (widx == 8)
                    check("filt_last", cur == {16'h0139, 1'b1, 3'd2, 3'd2, 1'b1},
                          cur, {16'h0139, 1'b1, 3'd2, 3'd2, 1'b1});
                if (widx == 9)
                    check("ifmap_first", cur == {16'h0100, 1'b0, 3'd0, 3'd0, 1'b0},
                          cur, {16'h0100, 1'b0, 3'd0, 3'd0, 1'b0});
            end
            if (prev_stall)
                check("stall_stable", out_valid && cur == prev_word,
                      {out_valid, cur}, {1'b1, prev_word});
            if (rom_read) begin
                check("issue_limit", (rd_cnt - pop_cnt - int'(pop)) < 2,
                      rd_cnt - pop_cnt - int'(pop), 1);
                if (issue_idx < 58)
                    check("issue_addr", rom_addr == exp_addr[issue_idx],
                          rom_addr, exp_addr[issue_idx]);
                else
                    check("extra_issue", 1'b0, rom_addr, 0);
                issue_idx++;
            end
            if (done) begin
                done_cnt++;
                check("done_after_all", widx == 58 && !out_valid, widx, 58);
            end
            if (rom_read) rd_cnt++;
            if (pop) begin
                widx++;
                pop_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = cur;
        end
    end

    task automatic run_pass(input int mode);
        int cyc;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            start = (mode == 2 && cyc == 20);
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        end while (done_cnt == 0 && cyc < 1000);
        if (cyc >= 1000) check("pass_timeout", 1'b0, cyc, 0);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("word_count", widx == 58, widx, 58);
        check("issue_count", issue_idx == 58, issue_idx, 58);
        check("done_once", done_cnt == 1, done_cnt, 1);
        check("idle_after", !busy && !out_valid && !rom_read,
              {busy, out_valid, rom_read}, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {rom_read, rom_addr, out_valid, out_data, out_is_filt,
              out_row, out_col, out_last, busy, done} == '0,
              {rom_read, rom_addr, out_valid, out_data, busy, done}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outs", !busy && !out_valid && !rom_read && !done,
              {busy, out_valid, rom_read, done}, 0);

        run_pass(0);
        run_pass(1);
        run_pass(1);
        run_pass(2);

        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (widx < 20 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reach", widx >= 20, widx, 20);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outs", {rom_read, rom_addr, out_valid, out_data,
              out_is_filt, out_row, out_col, out_last, busy, done} == '0,
              {rom_read, rom_addr, out_valid, out_data, busy, done}, 0);
        check("abort_no_done", done_cnt == 0, done_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_pass(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_stream_loader.md
Name: rom_stream_loader

Overview:
- Sequencer directly downstream of the 16-bit weight/activation ROM.
- The ROM holds a 7x7 ifmap at addresses 0..48 and a 3x3 filter at addresses 49..57.
- On start, the block walks the filter region, then the ifmap region. It drives the ROM read/address lines and absorbs the ROM's 1-cycle registered read latency.
- It streams each word to the PE-array scratchpad loaders over a valid/ready handshake with full backpressure, and tags every word with type, row/col and last.

Parameters:
- DATA_WIDTH, 16, ROM word width
- ADDR_WIDTH, 6, ROM address width
- IFMAP_SIZE, 7, ifmap side length (IFMAP_SIZE^2 words)
- FILT_SIZE, 3, filter side length (FILT_SIZE^2 words)
- IFMAP_BASE, 0, first ifmap address
- FILT_BASE, 49, first filter address

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a load pass
- rom_read  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_dout  in  DATA_WIDTH  ROM registered read data (undefined/Z when not read)
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_WIDTH  word
- out_is_filt  out  1  1 = filter word, 0 = ifmap word
- out_row  out  3  row index within the current matrix
- out_col  out  3  column index within the current matrix
- out_last  out  1  last word of the current matrix
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Reset forces:
  - all outputs to 0
  - the FSM to IDLE
  - the FIFO empty, the in-flight flag clear, and the counters to 0
- FSM states: IDLE, FILT, IFMAP, DRAIN.
  - IDLE: start=1 moves to FILT; busy=1 from the next cycle. start in any other state is ignored.
  - FILT: issues addresses FILT_BASE .. FILT_BASE+FILT_SIZE^2-1 in order. Moves to IFMAP the cycle after the last filter address is issued.
  - IFMAP: issues IFMAP_BASE .. IFMAP_BASE+IFMAP_SIZE^2-1. Moves to DRAIN after the last issue.
  - DRAIN: no issues. When the in-flight flag is clear, the FIFO is empty and no transfer is pending, it returns to IDLE, pulses done=1 for one cycle and drops busy.
- Read issue:
  - rom_read=1 only in FILT/IFMAP, with addresses remaining, and when (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
  - The path from out_ready to rom_read is combinational.
  - rom_addr holds its value when rom_read=0.
- Capture:
  - inflight is set on a read. One cycle later rom_dout is written into the FIFO together with its tags: type, row, col, last.
  - rom_dout is sampled only in the cycle after rom_read=1, never otherwise.
- Output FIFO:
  - 2-entry. out_* are driven from the head entry.
  - Data and tags stay stable while out_valid=1 and out_ready=0.
  - A pop and a push in the same cycle keep the count unchanged.
  - The FIFO never overflows, by construction of the issue rule.
- Tags:
  - row/col count column-fastest and wrap col at SIZE−1. Both reset to 0 at the matrix change.
  - out_last=1 on filter (2,2) and on ifmap (6,6).
- Latency:
  - First out_valid occurs 3 cycles after the start cycle.
  - With out_ready held at 1, one word is transferred per cycle, 58 consecutive words.
- Reset mid-pass: everything is abandoned and there is no done pulse. The next start restarts from FILT_BASE.
- Counters use $clog2(IFMAP_SIZE^2) bits. Address arithmetic wraps modulo 2^ADDR_WIDTH; the defaults never wrap.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE/FILT/IFMAP/DRAIN)
  - the defaults for IFMAP_SIZE, FILT_SIZE, IFMAP_BASE, FILT_BASE
  - a tagged-word struct: data, is_filt, row, col, last
- One sub-module, stream_fifo2: a 2-entry FIFO of the tagged-word struct with push/pop/count/full/empty.

Test Plan:
- ROM preloaded with data[i]=i+16'h0100; start at cycle 0, out_ready=1.
  - Cycle 1: rom_read=1, rom_addr=49.
  - Cycle 3: out_valid=1, data 16'h0131, filt, row0/col0.
  - 58 consecutive transfers, then done pulses once.
- Filter/ifmap boundary.
  - 9th word: data 16'h0139, out_is_filt=1, row2/col2, out_last=1.
  - 10th word: data 16'h0100, out_is_filt=0, row0/col0.
- Backpressure: out_ready toggles 1,0,0,1 randomly.
  - Every word is delivered exactly once, in order.
  - out_data is stable while stalled.
  - rom_read is never asserted with fifo_count+inflight already 2 and no pop.
- Start while busy, at cycle 20.
  - Ignored: total transfers = 58, exactly one done pulse.
- Async rst asserted mid-IFMAP, between clock edges.
  - Outputs go 0 immediately.
  - The next start re-emits 16'h0131 first.
- rom_dout driven to Z/X whenever rom_read was 0 the previous cycle.
  - No X ever appears on out_data while out_valid=1.
